// File: rtl/systolic_array_ws.sv
// Weight-stationary ARRAY_N x ARRAY_N systolic matrix-multiply engine: C = A x B, B held in the PEs.
// A rows stream in with input skew, psums flow down columns, and a deskew realigns each C row.
module systolic_array_ws #(
    parameter int ARRAY_N = 4,
    parameter int DATA_W  = 8,
    parameter int PSUM_W  = 24
) (
    input  logic                        s_clk,
    input  logic                        s_rst,
    input  logic                        w_valid,
    output logic                        w_ready,
    input  logic [ARRAY_N*DATA_W-1:0]   w_data,
    input  logic                        a_valid,
    output logic                        a_ready,
    input  logic [ARRAY_N*DATA_W-1:0]   a_data,
    input  logic                        a_last,
    output logic                        c_valid,
    input  logic                        c_ready,
    output logic [ARRAY_N*PSUM_W-1:0]   c_data,
    output logic                        c_last,
    output logic                        busy,
    output logic                        weights_loaded
);
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_LOAD_W = 2'd1;
    localparam logic [1:0] ST_STREAM = 2'd2;
    localparam logic [1:0] ST_DRAIN  = 2'd3;
    localparam int CNT_W  = $clog2(ARRAY_N);
    localparam int PIPE_D = 2 * ARRAY_N;

    logic [1:0]               r_state;
    logic [1:0]               w_state_nxt;
    logic [CNT_W-1:0]         r_wcnt;
    logic [CNT_W-1:0]         w_wrow;
    logic                     r_wloaded;
    logic [DATA_W-1:0]        r_b     [ARRAY_N][ARRAY_N];
    logic [DATA_W-1:0]        r_a     [ARRAY_N][ARRAY_N];
    logic [PSUM_W-1:0]        r_ps    [ARRAY_N][ARRAY_N];
    logic [DATA_W-1:0]        w_pe_a  [ARRAY_N][ARRAY_N];
    logic [PSUM_W-1:0]        w_pe_ps [ARRAY_N][ARRAY_N];
    logic [DATA_W-1:0]        w_skew_out [ARRAY_N];
    logic [PSUM_W-1:0]        w_dsk_out  [ARRAY_N];
    logic [ARRAY_N*PSUM_W-1:0] w_c_next;
    logic [PIPE_D-1:0]        r_vld;
    logic [PIPE_D-1:0]        r_lst;
    logic                     r_c_valid;
    logic                     r_c_last;
    logic [ARRAY_N*PSUM_W-1:0] r_c_data;
    logic                     w_en;
    logic                     w_w_acc;
    logic                     w_a_acc;
    logic                     w_c_acc;

    function automatic logic [PSUM_W-1:0] mac_term(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
        logic signed [2*DATA_W-1:0] p;
        p = $signed(a) * $signed(b);
        return PSUM_W'(p);
    endfunction

    // The whole datapath advances only when the output slot is free or being consumed.
    assign w_en    = !r_c_valid || c_ready;
    assign w_ready = (r_state == ST_IDLE) || (r_state == ST_LOAD_W);
    assign a_ready = (r_state == ST_STREAM) && w_en;
    assign w_w_acc = w_valid && w_ready;
    assign w_a_acc = a_valid && a_ready;
    assign w_c_acc = r_c_valid && c_ready;
    assign w_wrow  = (r_state == ST_IDLE) ? {CNT_W{1'b0}} : r_wcnt;

    assign busy           = (r_state != ST_IDLE);
    assign weights_loaded = r_wloaded;
    assign c_valid        = r_c_valid;
    assign c_last         = r_c_last;
    assign c_data         = r_c_data;

    // Next-state decode; a weight beat in IDLE wins over a pending A row.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_w_acc)                     w_state_nxt = ST_LOAD_W;
                else if (a_valid && r_wloaded)   w_state_nxt = ST_STREAM;
                else                             w_state_nxt = ST_IDLE;
            end
            ST_LOAD_W: begin
                if (w_w_acc && (r_wcnt == CNT_W'(ARRAY_N - 1))) w_state_nxt = ST_STREAM;
                else                                            w_state_nxt = ST_LOAD_W;
            end
            ST_STREAM: begin
                if (w_a_acc && a_last) w_state_nxt = ST_DRAIN;
                else                   w_state_nxt = ST_STREAM;
            end
            ST_DRAIN: begin
                if (w_c_acc && r_c_last) w_state_nxt = ST_IDLE;
                else                     w_state_nxt = ST_DRAIN;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Control state, weight row counter and the stationary B tile.
    always_ff @(posedge s_clk or posedge s_rst) begin
        if (s_rst) begin
            r_state   <= ST_IDLE;
            r_wcnt    <= {CNT_W{1'b0}};
            r_wloaded <= 1'b0;
            for (int k = 0; k < ARRAY_N; k++)
                for (int n = 0; n < ARRAY_N; n++)
                    r_b[k][n] <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_w_acc) begin
                for (int n = 0; n < ARRAY_N; n++)
                    r_b[w_wrow][n] <= w_data[n*DATA_W +: DATA_W];
                if (r_state == ST_IDLE) begin
                    r_wcnt    <= CNT_W'(1);
                    r_wloaded <= 1'b0;
                end else if (r_wcnt == CNT_W'(ARRAY_N - 1)) begin
                    r_wcnt    <= {CNT_W{1'b0}};
                    r_wloaded <= 1'b1;
                end else begin
                    r_wcnt    <= r_wcnt + CNT_W'(1);
                end
            end
        end
    end

    genvar gk, gn;
    generate
        for (gk = 0; gk < ARRAY_N; gk++) begin : g_skew
            logic [DATA_W-1:0] r_sk [gk+1];
            // Element k of the accepted row is delayed k extra cycles; bubbles enter as zero.
            always_ff @(posedge s_clk or posedge s_rst) begin
                if (s_rst) begin
                    for (int j = 0; j <= gk; j++) r_sk[j] <= '0;
                end else if (w_en) begin
                    r_sk[0] <= w_a_acc ? a_data[gk*DATA_W +: DATA_W] : {DATA_W{1'b0}};
                    for (int j = 1; j <= gk; j++) r_sk[j] <= r_sk[j-1];
                end
            end
            assign w_skew_out[gk] = r_sk[gk];
        end

        for (gk = 0; gk < ARRAY_N; gk++) begin : g_row
            for (gn = 0; gn < ARRAY_N; gn++) begin : g_col
                if (gn == 0) begin : g_a_edge
                    assign w_pe_a[gk][gn] = w_skew_out[gk];
                end else begin : g_a_in
                    assign w_pe_a[gk][gn] = r_a[gk][gn-1];
                end
                if (gk == 0) begin : g_ps_top
                    assign w_pe_ps[gk][gn] = '0;
                end else begin : g_ps_in
                    assign w_pe_ps[gk][gn] = r_ps[gk-1][gn];
                end
            end
        end

        for (gn = 0; gn < ARRAY_N; gn++) begin : g_deskew
            localparam int D = ARRAY_N - 1 - gn;
            if (D == 0) begin : g_direct
                assign w_dsk_out[gn] = r_ps[ARRAY_N-1][gn];
            end else begin : g_delay
                logic [PSUM_W-1:0] r_d [D];
                // Earlier-finishing columns wait so the whole row leaves together.
                always_ff @(posedge s_clk or posedge s_rst) begin
                    if (s_rst) begin
                        for (int j = 0; j < D; j++) r_d[j] <= '0;
                    end else if (w_en) begin
                        r_d[0] <= r_ps[ARRAY_N-1][gn];
                        for (int j = 1; j < D; j++) r_d[j] <= r_d[j-1];
                    end
                end
                assign w_dsk_out[gn] = r_d[D-1];
            end
            assign w_c_next[gn*PSUM_W +: PSUM_W] = w_dsk_out[gn];
        end
    endgenerate

    // PE grid: A moves right, psum moves down, products wrap modulo 2^PSUM_W.
    always_ff @(posedge s_clk or posedge s_rst) begin
        if (s_rst) begin
            for (int k = 0; k < ARRAY_N; k++)
                for (int n = 0; n < ARRAY_N; n++) begin
                    r_a[k][n]  <= '0;
                    r_ps[k][n] <= '0;
                end
        end else if (w_en) begin
            for (int k = 0; k < ARRAY_N; k++)
                for (int n = 0; n < ARRAY_N; n++) begin
                    r_a[k][n]  <= w_pe_a[k][n];
                    r_ps[k][n] <= w_pe_ps[k][n] + mac_term(w_pe_a[k][n], r_b[k][n]);
                end
        end
    end

    // Valid/last tokens track each row through the 2*ARRAY_N stage pipe into the output register.
    always_ff @(posedge s_clk or posedge s_rst) begin
        if (s_rst) begin
            r_vld     <= '0;
            r_lst     <= '0;
            r_c_valid <= 1'b0;
            r_c_last  <= 1'b0;
            r_c_data  <= '0;
        end else if (w_en) begin
            r_vld     <= {r_vld[PIPE_D-2:0], w_a_acc};
            r_lst     <= {r_lst[PIPE_D-2:0], w_a_acc && a_last};
            r_c_valid <= r_vld[PIPE_D-1];
            r_c_last  <= r_lst[PIPE_D-1];
            r_c_data  <= w_c_next;
        end
    end
endmodule

// File: tb/tb_systolic_array_ws.sv
// Directed scoreboard bench for systolic_array_ws (N=4, DATA_W=8, PSUM_W=24).
module tb_systolic_array_ws;
    localparam int N  = 4;
    localparam int DW = 8;
    localparam int PW = 24;

    logic            s_clk, s_rst;
    logic            w_valid, w_ready, a_valid, a_ready, a_last;
    logic [N*DW-1:0] w_data, a_data;
    logic            c_valid, c_ready, c_last, busy, weights_loaded;
    logic [N*PW-1:0] c_data;

    systolic_array_ws #(.ARRAY_N(N), .DATA_W(DW), .PSUM_W(PW)) dut (
        .s_clk(s_clk), .s_rst(s_rst),
        .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
        .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data), .a_last(a_last),
        .c_valid(c_valid), .c_ready(c_ready), .c_data(c_data), .c_last(c_last),
        .busy(busy), .weights_loaded(weights_loaded)
    );

    typedef struct packed { logic last; logic [N*PW-1:0] data; } exp_t;
    exp_t q[$];

    int  errors = 0, checks = 0;
    int  cyc = 0, hs_cnt = 0, last_hs_cyc = 0, first_cval_cyc = -1;
    bit  last_seen = 1'b0;

    initial begin
        s_clk = 1'b0;
        forever #5 s_clk = ~s_clk;
    end

    initial forever begin
        @(posedge s_clk);
        cyc++;
    end

    function automatic logic [N*DW-1:0] pa(input int e0, input int e1, input int e2, input int e3);
        return {8'(e3), 8'(e2), 8'(e1), 8'(e0)};
    endfunction

    function automatic logic [N*PW-1:0] pc(input int e0, input int e1, input int e2, input int e3);
        return {24'(e3), 24'(e2), 24'(e1), 24'(e0)};
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s act=%0h req=%0h", nm, act, req);
        end
    endtask

    task automatic tick();
        @(posedge s_clk);
        #1;
    endtask

    // Monitor: compares every presented C beat against the scoreboard head.
    initial forever begin
        @(negedge s_clk);
        if (!s_rst && c_valid) begin
            if (first_cval_cyc < 0) first_cval_cyc = cyc;
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_c act=%0h/%0b req=none", c_data, c_last);
            end else if (c_data !== q[0].data || c_last !== q[0].last) begin
                errors++;
                $display("FAIL c_beat act=%0h/%0b req=%0h/%0b", c_data, c_last, q[0].data, q[0].last);
            end
            if (!c_ready) begin
                checks++;
                if (a_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL stall_a_ready act=%0b req=0", a_ready);
                end
            end else begin
                if (q.size() > 0) void'(q.pop_front());
                hs_cnt++;
                if (c_last) begin
                    checks++;
                    if (busy !== 1'b1) begin
                        errors++;
                        $display("FAIL busy_at_last act=%0b req=1", busy);
                    end
                    last_seen   = 1'b1;
                    last_hs_cyc = cyc;
                end
            end
        end
    end

    task automatic load_w(input logic [N*DW-1:0] r0, input logic [N*DW-1:0] r1,
                          input logic [N*DW-1:0] r2, input logic [N*DW-1:0] r3);
        logic [N*DW-1:0] rows [N];
        rows = '{r0, r1, r2, r3};
        for (int k = 0; k < N; k++) begin
            int t = 0;
            w_valid = 1'b1;
            w_data  = rows[k];
            forever begin
                @(negedge s_clk);
                if (w_ready) break;
                t++;
                if (t > 50) break;
            end
            chk("w_accept", {127'd0, w_ready}, 128'd1);
            chk("load_a_ready", {127'd0, a_ready}, 128'd0);
            tick();
        end
        w_valid = 1'b0;
        chk("weights_loaded", {127'd0, weights_loaded}, 128'd1);
    endtask

    task automatic send_row(input logic [N*DW-1:0] d, input bit last, input logic [N*PW-1:0] e,
                            output int acc);
        int t = 0;
        acc     = -1;
        a_valid = 1'b1;
        a_data  = d;
        a_last  = last;
        forever begin
            @(negedge s_clk);
            if (a_ready) begin
                acc = cyc;
                q.push_back({last, e});
                break;
            end
            t++;
            if (t > 50) break;
        end
        if (acc < 0) chk("a_accept_timeout", 128'd0, 128'd1);
        tick();
    endtask

    task automatic wait_done();
        int t = 0;
        while (!last_seen && t < 200) begin
            tick();
            t++;
        end
        if (!last_seen) begin
            chk("last_timeout", 128'd0, 128'd1);
        end else begin
            chk("busy_after_last", {127'd0, busy}, 128'd0);
            chk("idle_w_ready", {127'd0, w_ready}, 128'd1);
        end
    endtask

    initial begin
        int acc, acc0, d3, d4, base, t;
        bit took;
        s_rst = 1'b1; w_valid = 1'b0; a_valid = 1'b0; a_last = 1'b0;
        c_ready = 1'b1; w_data = '0; a_data = '0;
        repeat (2) tick();
        chk("rst_a_ready", {127'd0, a_ready}, 128'd0);
        chk("rst_c_valid", {127'd0, c_valid}, 128'd0);
        chk("rst_c_last", {127'd0, c_last}, 128'd0);
        chk("rst_c_data", {32'd0, c_data}, 128'd0);
        chk("rst_busy", {127'd0, busy}, 128'd0);
        chk("rst_wl", {127'd0, weights_loaded}, 128'd0);
        chk("rst_w_ready", {127'd0, w_ready}, 128'd1);
        s_rst = 1'b0;
        tick();

        // Identity B: C row equals A row, 8 edges after acceptance (+1 for negedge sampling).
        load_w(pa(1,0,0,0), pa(0,1,0,0), pa(0,0,1,0), pa(0,0,0,1));
        last_seen = 1'b0; first_cval_cyc = -1;
        send_row(pa(1,2,3,4), 1'b1, pc(1,2,3,4), acc);
        a_valid = 1'b0;
        wait_done();
        chk("latency", 128'(first_cval_cyc - acc), 128'd9);

        // Extreme signed values: 4*(-128*-128)=65536, 4*(127*-128)=-65024.
        load_w(pa(-128,-128,-128,-128), pa(-128,-128,-128,-128),
               pa(-128,-128,-128,-128), pa(-128,-128,-128,-128));
        last_seen = 1'b0;
        send_row(pa(-128,-128,-128,-128), 1'b0, pc(65536,65536,65536,65536), acc);
        send_row(pa(127,127,127,127), 1'b1, pc(-65024,-65024,-65024,-65024), acc);
        a_valid = 1'b0;
        wait_done();

        // Six back-to-back rows, B all ones: C = 4m.
        load_w(pa(1,1,1,1), pa(1,1,1,1), pa(1,1,1,1), pa(1,1,1,1));
        last_seen = 1'b0;
        for (int m = 1; m <= 6; m++) begin
            send_row(pa(m,m,m,m), (m == 6), pc(4*m,4*m,4*m,4*m), acc);
            if (m == 1) acc0 = acc;
        end
        a_valid = 1'b0;
        wait_done();
        d3 = last_hs_cyc - acc0;
        chk("run_len_nostall", 128'(d3), 128'd14);

        // Same batch on reused weights with a 5-cycle stall at the 2nd C beat.
        last_seen = 1'b0;
        base = hs_cnt;
        for (int m = 1; m <= 6; m++) begin
            send_row(pa(m,m,m,m), (m == 6), pc(4*m,4*m,4*m,4*m), acc);
            if (m == 1) acc0 = acc;
        end
        a_valid = 1'b0;
        t = 0;
        while (hs_cnt != base + 1 && t < 100) begin
            tick();
            t++;
        end
        chk("first_beat_seen", 128'(hs_cnt - base), 128'd1);
        c_ready = 1'b0;
        repeat (5) tick();
        c_ready = 1'b1;
        wait_done();
        d4 = last_hs_cyc - acc0;
        chk("run_len_stall", 128'(d4), 128'd19);

        // Weight beat and A row together in IDLE: weights load first, then A uses B=2I.
        last_seen = 1'b0;
        a_valid = 1'b1; a_data = pa(5,6,7,8); a_last = 1'b1;
        load_w(pa(2,0,0,0), pa(0,2,0,0), pa(0,0,2,0), pa(0,0,0,2));
        send_row(pa(5,6,7,8), 1'b1, pc(10,12,14,16), acc);
        a_valid = 1'b0;
        wait_done();

        // Reset with three rows in flight; A must be refused until a full reload.
        for (int m = 1; m <= 3; m++) send_row(pa(m,m,m,m), 1'b0, pc(0,0,0,0), acc);
        s_rst = 1'b1;
        #1;
        chk("midrst_c_valid", {127'd0, c_valid}, 128'd0);
        chk("midrst_wl", {127'd0, weights_loaded}, 128'd0);
        chk("midrst_busy", {127'd0, busy}, 128'd0);
        q.delete();
        tick();
        s_rst = 1'b0;
        a_valid = 1'b1; a_data = pa(9,9,9,9); a_last = 1'b1;
        took = 1'b0;
        repeat (20) begin
            @(negedge s_clk);
            if (a_ready) took = 1'b1;
        end
        chk("no_accept_unloaded", {127'd0, took}, 128'd0);
        tick();
        a_valid = 1'b0;
        load_w(pa(1,1,1,1), pa(1,1,1,1), pa(1,1,1,1), pa(1,1,1,1));
        last_seen = 1'b0;
        send_row(pa(1,2,3,4), 1'b1, pc(10,10,10,10), acc);
        a_valid = 1'b0;
        wait_done();
        chk("scoreboard_empty", 128'(q.size()), 128'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
